cjb_alu_ctrl_v: RTL and testbench

Two-requester sequencer for the shared 8-bit ALU (constant, logic, arithmetic and shift units). It arbitrates between two requesters: Req0, the instruction datapath, and Req1, the debug/load path. It registers the winner's operation onto the ALU select and operand lines and captures the ALU result. It also maintains the architectural CNVZ flag register, which is updated only when the requester asks for it.

---
 rtl/cjb_alu_ctrl_v_pkg.sv | 31 +++
 rtl/cjb_alu_ctrl_v_arbiter.sv | 18 +
 rtl/cjb_alu_ctrl_v.sv | 115 +++++++++++
 tb/tb_cjb_alu_ctrl_v.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cjb_alu_ctrl_v_pkg.sv
// Shared encodings for the ALU sequencer: unit selects, FSM states, flag
// bit positions and the captured request record.
package cjb_alu_ctrl_v_pkg;

  // ALU unit-select encodings (upper half of Op)
  localparam logic [1:0] UNIT_CONST = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_ARITH = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  // Sequencer FSM states
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_WB   = 2'b10;

  // Bit positions inside a CNVZ nibble
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  // Request fields sampled from the winning requester on accept
  typedef struct packed {
    logic [1:0] unit_sel;
    logic [1:0] func_sel;
    logic [7:0] a;
    logic [7:0] b;
    logic       set_flags;
  } alu_req_t;

endpackage

// File: rtl/cjb_alu_ctrl_v_arbiter.sv
// Two-way combinational arbiter. Round-robin favours the requester that
// did not win last; fixed mode always favours requester 0.
module cjb_rr_arbiter2_v (
  input  logic Valid0,
  input  logic Valid1,
  input  logic Last_Grant,
  input  logic RR_EN,
  output logic Grant0,
  output logic Grant1
);

  // Req0 wins when alone, in fixed mode, or when Req1 had the last grant
  always_comb begin
    Grant0 = Valid0 & (~Valid1 | ~RR_EN | Last_Grant);
    Grant1 = Valid1 & ~Grant0;
  end

endmodule

// File: rtl/cjb_alu_ctrl_v.sv
// Two-requester sequencer for the shared 8-bit ALU. Accepts one operation
// per visit to IDLE/WB, drives registered ALU selects/operands during EXEC,
// then captures result and (optionally) flags at the end of EXEC.
module cjb_alu_ctrl_v
  import cjb_alu_ctrl_v_pkg::*;
#(
  parameter logic RR_EN = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Req0_Valid,
  input  logic [3:0] Req0_Op,
  input  logic [7:0] Req0_A,
  input  logic [7:0] Req0_B,
  input  logic       Req0_SetFlags,
  output logic       Req0_Ready,
  input  logic       Req1_Valid,
  input  logic [3:0] Req1_Op,
  input  logic [7:0] Req1_A,
  input  logic [7:0] Req1_B,
  input  logic       Req1_SetFlags,
  output logic       Req1_Ready,
  output logic [1:0] ALU_Unit_Sel,
  output logic [1:0] ALU_Func_Sel,
  output logic [7:0] ALU_A,
  output logic [7:0] ALU_B,
  input  logic [7:0] ALU_Result,
  input  logic [3:0] ALU_CNVZ,
  output logic [7:0] Result,
  output logic       Result_Src,
  output logic       Done,
  output logic [3:0] CNVZ,
  output logic       Busy
);

  logic [1:0] state;
  logic       last_grant;
  logic       lat_id;
  logic       lat_sf;
  logic       grant0, grant1;
  logic       can_accept;
  logic       accept;
  alu_req_t   win;

  cjb_rr_arbiter2_v u_arb (
    .Valid0     (Req0_Valid),
    .Valid1     (Req1_Valid),
    .Last_Grant (last_grant),
    .RR_EN      (RR_EN),
    .Grant0     (grant0),
    .Grant1     (grant1)
  );

  // Ready only to the winner, only in IDLE/WB, and never while in reset
  always_comb begin
    can_accept = ~Reset & ((state == ST_IDLE) | (state == ST_WB));
    Req0_Ready = can_accept & grant0;
    Req1_Ready = can_accept & grant1;
    accept     = (Req0_Valid & Req0_Ready) | (Req1_Valid & Req1_Ready);
  end

  // Select the winning requester's fields for loading into the ALU registers
  always_comb begin
    if (grant1)
      win = {Req1_Op, Req1_A, Req1_B, Req1_SetFlags};
    else
      win = {Req0_Op, Req0_A, Req0_B, Req0_SetFlags};
  end

  assign Busy = (state == ST_EXEC);
  assign Done = (state == ST_WB);

  // Sequencer: accept -> EXEC (ALU settles) -> WB (capture visible, Done)
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= ST_IDLE;
      last_grant   <= 1'b1;
      lat_id       <= 1'b0;
      lat_sf       <= 1'b0;
      ALU_Unit_Sel <= UNIT_CONST;
      ALU_Func_Sel <= 2'b00;
      ALU_A        <= 8'h00;
      ALU_B        <= 8'h00;
      Result       <= 8'h00;
      Result_Src   <= 1'b0;
      CNVZ         <= 4'b0000;
    end else begin
      case (state)
        ST_IDLE, ST_WB: begin
          if (accept) begin
            ALU_Unit_Sel <= win.unit_sel;
            ALU_Func_Sel <= win.func_sel;
            ALU_A        <= win.a;
            ALU_B        <= win.b;
            lat_id       <= grant1;
            lat_sf       <= win.set_flags;
            last_grant   <= grant1;
            state        <= ST_EXEC;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          Result     <= ALU_Result;
          Result_Src <= lat_id;
          if (lat_sf)
            CNVZ <= ALU_CNVZ;
          state <= ST_WB;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cjb_alu_ctrl_v.sv
// Bench for cjb_alu_ctrl_v: a round-robin and a fixed-priority instance
// share the request inputs, each driving its own behavioural ALU model.
// Per-instance scoreboards queue expected completions at accept time and
// compare them on every Done pulse.
module tb_cjb_alu_ctrl_v;

  logic       clk = 1'b0;
  logic       rst;
  logic       r0v, r0sf, r1v, r1sf;
  logic [3:0] r0op, r1op;
  logic [7:0] r0a, r0b, r1a, r1b;

  logic       rr_r0rdy, rr_r1rdy, rr_src, rr_done, rr_busy;
  logic [1:0] rr_unit, rr_func;
  logic [7:0] rr_alua, rr_alub, rr_result;
  logic [3:0] rr_cnvz;
  logic [11:0] rr_alu;

  logic       fp_r0rdy, fp_r1rdy, fp_src, fp_done, fp_busy;
  logic [1:0] fp_unit, fp_func;
  logic [7:0] fp_alua, fp_alub, fp_result;
  logic [3:0] fp_cnvz;
  logic [11:0] fp_alu;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] res;
    logic       src;
    logic [3:0] cnvz;
  } exp_t;

  exp_t q_rr[$];
  exp_t q_fp[$];
  logic [3:0] f_rr, f_fp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: returns {C,N,V,Z,result}
  function automatic logic [11:0] alu_m(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; r = 8'h00; w = 9'h000;
    case (op[3:2])
      2'b00: case (op[1:0])
        2'b00: r = 8'h00;
        2'b01: r = 8'h55;
        2'b10: r = 8'hAA;
        default: r = 8'hFF;
      endcase
      2'b01: case (op[1:0])
        2'b00: r = a & b;
        2'b01: r = a | b;
        2'b10: r = a ^ b;
        default: r = ~a;
      endcase
      2'b10: begin
        case (op[1:0])
          2'b00: w = {1'b0, a} + {1'b0, b};
          2'b01: w = {1'b0, a} - {1'b0, b};
          2'b10: w = {1'b0, a} + 9'd1;
          default: w = {1'b0, a} - 9'd1;
        endcase
        r = w[7:0];
        c = w[8];
        if (op[1:0] == 2'b00) v = (a[7] == b[7]) && (r[7] != a[7]);
        if (op[1:0] == 2'b01) v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      default: case (op[1:0])
        2'b00: begin r = {a[6:0], 1'b0}; c = a[7]; end
        2'b01: begin r = {1'b0, a[7:1]}; c = a[0]; end
        2'b10: begin r = {a[7], a[7:1]}; c = a[0]; end
        default: begin r = {a[6:0], a[7]}; c = a[7]; end
      endcase
    endcase
    return {c, r[7], v, (r == 8'h00), r};
  endfunction

  assign rr_alu = alu_m({rr_unit, rr_func}, rr_alua, rr_alub);
  assign fp_alu = alu_m({fp_unit, fp_func}, fp_alua, fp_alub);

  cjb_alu_ctrl_v #(.RR_EN(1'b1)) u_rr (
    .Clock(clk), .Reset(rst),
    .Req0_Valid(r0v), .Req0_Op(r0op), .Req0_A(r0a), .Req0_B(r0b), .Req0_SetFlags(r0sf), .Req0_Ready(rr_r0rdy),
    .Req1_Valid(r1v), .Req1_Op(r1op), .Req1_A(r1a), .Req1_B(r1b), .Req1_SetFlags(r1sf), .Req1_Ready(rr_r1rdy),
    .ALU_Unit_Sel(rr_unit), .ALU_Func_Sel(rr_func), .ALU_A(rr_alua), .ALU_B(rr_alub),
    .ALU_Result(rr_alu[7:0]), .ALU_CNVZ(rr_alu[11:8]),
    .Result(rr_result), .Result_Src(rr_src), .Done(rr_done), .CNVZ(rr_cnvz), .Busy(rr_busy)
  );

  cjb_alu_ctrl_v #(.RR_EN(1'b0)) u_fp (
    .Clock(clk), .Reset(rst),
    .Req0_Valid(r0v), .Req0_Op(r0op), .Req0_A(r0a), .Req0_B(r0b), .Req0_SetFlags(r0sf), .Req0_Ready(fp_r0rdy),
    .Req1_Valid(r1v), .Req1_Op(r1op), .Req1_A(r1a), .Req1_B(r1b), .Req1_SetFlags(r1sf), .Req1_Ready(fp_r1rdy),
    .ALU_Unit_Sel(fp_unit), .ALU_Func_Sel(fp_func), .ALU_A(fp_alua), .ALU_B(fp_alub),
    .ALU_Result(fp_alu[7:0]), .ALU_CNVZ(fp_alu[11:8]),
    .Result(fp_result), .Result_Src(fp_src), .Done(fp_done), .CNVZ(fp_cnvz), .Busy(fp_busy)
  );

  // Scoreboard for the round-robin instance
  always @(negedge clk) begin : mon_rr
    exp_t e;
    logic [11:0] t;
    if (rst) begin
      q_rr.delete();
      f_rr = 4'b0000;
    end else begin
      if (rr_done) begin
        checks++;
        if (q_rr.size() == 0) begin
          errors++;
          $display("FAIL rr_unexpected_done: result=%h src=%0d with nothing outstanding", rr_result, rr_src);
        end else begin
          e = q_rr.pop_front();
          if ({rr_result, rr_src, rr_cnvz} !== {e.res, e.src, e.cnvz}) begin
            errors++;
            $display("FAIL rr_done: got res=%h src=%0d cnvz=%b, want res=%h src=%0d cnvz=%b",
                     rr_result, rr_src, rr_cnvz, e.res, e.src, e.cnvz);
          end
        end
      end
      if (r0v && rr_r0rdy) begin
        t = alu_m(r0op, r0a, r0b);
        if (r0sf) f_rr = t[11:8];
        e.res = t[7:0]; e.src = 1'b0; e.cnvz = f_rr;
        q_rr.push_back(e);
      end
      if (r1v && rr_r1rdy) begin
        t = alu_m(r1op, r1a, r1b);
        if (r1sf) f_rr = t[11:8];
        e.res = t[7:0]; e.src = 1'b1; e.cnvz = f_rr;
        q_rr.push_back(e);
      end
    end
  end

  // Scoreboard for the fixed-priority instance
  always @(negedge clk) begin : mon_fp
    exp_t e;
    logic [11:0] t;
    if (rst) begin
      q_fp.delete();
      f_fp = 4'b0000;
    end else begin
      if (fp_done) begin
        checks++;
        if (q_fp.size() == 0) begin
          errors++;
          $display("FAIL fp_unexpected_done: result=%h src=%0d with nothing outstanding", fp_result, fp_src);
        end else begin
          e = q_fp.pop_front();
          if ({fp_result, fp_src, fp_cnvz} !== {e.res, e.src, e.cnvz}) begin
            errors++;
            $display("FAIL fp_done: got res=%h src=%0d cnvz=%b, want res=%h src=%0d cnvz=%b",
                     fp_result, fp_src, fp_cnvz, e.res, e.src, e.cnvz);
          end
        end
      end
      if (r0v && fp_r0rdy) begin
        t = alu_m(r0op, r0a, r0b);
        if (r0sf) f_fp = t[11:8];
        e.res = t[7:0]; e.src = 1'b0; e.cnvz = f_fp;
        q_fp.push_back(e);
      end
      if (r1v && fp_r1rdy) begin
        t = alu_m(r1op, r1a, r1b);
        if (r1sf) f_fp = t[11:8];
        e.res = t[7:0]; e.src = 1'b1; e.cnvz = f_fp;
        q_fp.push_back(e);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; r0v = 1'b0; r1v = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Present one request on the round-robin instance; returns the accept cycle
  task automatic issue(input bit id, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input bit sf, output int acc);
    bit got;
    got = 1'b0;
    acc = 0;
    if (id) begin r1v = 1'b1; r1op = op; r1a = a; r1b = b; r1sf = sf; end
    else    begin r0v = 1'b1; r0op = op; r0a = a; r0b = b; r0sf = sf; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (id ? rr_r1rdy : rr_r0rdy) begin got = 1'b1; acc = cyc; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL issue_timeout: req%0d op=%b never accepted", id, op);
    end
    @(posedge clk); #1;
    if (id) r1v = 1'b0; else r0v = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; r0v = 1'b1; r1v = 1'b1;
    @(negedge clk);
    checks++;
    if ({rr_r0rdy, rr_r1rdy, fp_r0rdy, fp_r1rdy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got %b, want 0000", {rr_r0rdy, rr_r1rdy, fp_r0rdy, fp_r1rdy});
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({rr_unit, rr_func, rr_alua, rr_alub, rr_result, rr_src, rr_done, rr_cnvz, rr_busy} !== 36'h0) begin
      errors++;
      $display("FAIL reset_values: unit=%b func=%b a=%h b=%h res=%h src=%b done=%b cnvz=%b busy=%b, want all zero",
               rr_unit, rr_func, rr_alua, rr_alub, rr_result, rr_src, rr_done, rr_cnvz, rr_busy);
    end
    r0v = 1'b0; r1v = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_const();
    int acc;
    issue(1'b0, 4'b0010, 8'h12, 8'h34, 1'b1, acc);
    @(negedge clk);
    checks++;
    if ({rr_busy, rr_done, rr_unit, rr_func, rr_alua, rr_alub} !== {2'b10, 4'b0010, 8'h12, 8'h34}) begin
      errors++;
      $display("FAIL exec_cycle: busy=%b done=%b sel=%b%b a=%h b=%h, want busy=1 done=0 sel=0010 a=12 b=34",
               rr_busy, rr_done, rr_unit, rr_func, rr_alua, rr_alub);
    end
    @(negedge clk);
    checks++;
    if ({rr_done, rr_result, rr_src, rr_cnvz} !== {1'b1, 8'hAA, 1'b0, 4'b0100} || cyc != acc + 2) begin
      errors++;
      $display("FAIL const_aa: done=%b res=%h src=%b cnvz=%b at +%0d, want done=1 res=aa src=0 cnvz=0100 at +2",
               rr_done, rr_result, rr_src, rr_cnvz, cyc - acc);
    end
    issue(1'b0, 4'b0000, 8'h77, 8'h00, 1'b1, acc);
    repeat (2) @(negedge clk);
    checks++;
    if ({rr_done, rr_result, rr_cnvz} !== {1'b1, 8'h00, 4'b0001}) begin
      errors++;
      $display("FAIL const_zero: done=%b res=%h cnvz=%b, want done=1 res=00 cnvz=0001", rr_done, rr_result, rr_cnvz);
    end
    issue(1'b0, 4'b0011, 8'h01, 8'h02, 1'b0, acc);
    repeat (2) @(negedge clk);
    checks++;
    if ({rr_done, rr_result, rr_cnvz} !== {1'b1, 8'hFF, 4'b0001}) begin
      errors++;
      $display("FAIL const_ones_noflags: done=%b res=%h cnvz=%b, want done=1 res=ff cnvz=0001", rr_done, rr_result, rr_cnvz);
    end
  endtask

  task automatic test_round_robin();
    int prev;
    bit got;
    do_reset();
    r0op = 4'b1000; r0a = 8'h7F; r0b = 8'h01; r0sf = 1'b1;
    r1op = 4'b0110; r1a = 8'hF0; r1b = 8'h3C; r1sf = 1'b1;
    r0v = 1'b1; r1v = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (rr_r0rdy || rr_r1rdy) got = 1'b1;
      end
      checks++;
      if (!got || rr_r0rdy !== (k % 2 == 0) || rr_r1rdy !== (k % 2 == 1) || (k > 0 && cyc - prev != 2)) begin
        errors++;
        $display("FAIL rr_grant%0d: got=%b rdy0=%b rdy1=%b gap=%0d, want rdy%0d gap=2",
                 k, got, rr_r0rdy, rr_r1rdy, cyc - prev, k % 2);
      end
      prev = cyc;
      @(posedge clk); #1;
      if (k % 2 == 0) begin r0op = 4'($urandom_range(4, 15)); r0a = 8'($urandom); r0b = 8'($urandom); end
      else            begin r1op = 4'($urandom_range(4, 15)); r1a = 8'($urandom); r1b = 8'($urandom); end
    end
    r0v = 1'b0; r1v = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_fixed_priority();
    int n;
    bit got;
    do_reset();
    r0op = 4'b0101; r0a = 8'h0F; r0b = 8'h30; r0sf = 1'b1;
    r1op = 4'b1010; r1a = 8'hFF; r1b = 8'h00; r1sf = 1'b1;
    r0v = 1'b1; r1v = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (fp_r1rdy !== 1'b0) begin
        errors++;
        $display("FAIL fp_req1_ready: cycle %0d got %b, want 0 while Req0 valid", i, fp_r1rdy);
      end
      if (fp_r0rdy) n++;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL fp_req0_accepts: got %0d, want 4", n);
    end
    @(posedge clk); #1;
    r0v = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (fp_r1rdy) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL fp_req1_after_drop: got no accept, want accept");
    end
    @(posedge clk); #1;
    r1v = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int a1, a2;
    bit got;
    do_reset();
    r1op = 4'b0001; r1a = 8'h00; r1b = 8'h00; r1sf = 1'b1; r1v = 1'b1;
    got = 1'b0; a1 = 0; a2 = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (rr_r1rdy) begin got = 1'b1; a1 = cyc; end
    end
    @(posedge clk); #1;
    r1op = 4'b0010;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (rr_r1rdy) begin got = 1'b1; a2 = cyc; end
    end
    checks++;
    if (!got || a2 - a1 != 2 || {rr_done, rr_result, rr_src} !== {1'b1, 8'h55, 1'b1}) begin
      errors++;
      $display("FAIL b2b_first: gap=%0d done=%b res=%h src=%b, want gap=2 done=1 res=55 src=1",
               a2 - a1, rr_done, rr_result, rr_src);
    end
    @(posedge clk); #1;
    r1v = 1'b0;
    @(negedge clk);
    checks++;
    if ({rr_done, rr_busy} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_gap: done=%b busy=%b, want done=0 busy=1", rr_done, rr_busy);
    end
    @(negedge clk);
    checks++;
    if ({rr_done, rr_result, rr_cnvz} !== {1'b1, 8'hAA, 4'b0100}) begin
      errors++;
      $display("FAIL b2b_second: done=%b res=%h cnvz=%b, want done=1 res=aa cnvz=0100", rr_done, rr_result, rr_cnvz);
    end
  endtask

  task automatic test_reset_in_exec();
    int acc;
    do_reset();
    issue(1'b0, 4'b0011, 8'h00, 8'h00, 1'b1, acc);
    checks++;
    if (rr_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_exec_busy: got %b, want 1", rr_busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({rr_done, fp_done, rr_busy, rr_result, rr_cnvz, rr_unit, rr_func, rr_alua} !== 27'h0) begin
        errors++;
        $display("FAIL rst_exec_discard%0d: done=%b/%b busy=%b res=%h cnvz=%b sel=%b%b a=%h, want all zero",
                 i, rr_done, fp_done, rr_busy, rr_result, rr_cnvz, rr_unit, rr_func, rr_alua);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    r0v = 1'b0; r0op = 4'h0; r0a = 8'h00; r0b = 8'h00; r0sf = 1'b0;
    r1v = 1'b0; r1op = 4'h0; r1a = 8'h00; r1b = 8'h00; r1sf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_const();
    test_round_robin();
    test_fixed_priority();
    test_back_to_back();
    test_reset_in_exec();
    checks++;
    if (q_rr.size() != 0 || q_fp.size() != 0) begin
      errors++;
      $display("FAIL drain: outstanding rr=%0d fp=%0d, want 0 and 0", q_rr.size(), q_fp.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
